// File: rtl/hdmi_cfg_pkg.sv
// rtl/hdmi_cfg_pkg.sv - shared types and defaults for the ADV7511 configuration sequencer
package hdmi_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_PWR = 4'd1,
        ST_FETCH    = 4'd2,
        ST_REQ      = 4'd3,
        ST_WAIT_ACK = 4'd4,
        ST_NEXT     = 4'd5,
        ST_RETRY    = 4'd6,
        ST_DONE     = 4'd7,
        ST_FAIL     = 4'd8
    } state_e;

    // A LUT entry with this device address terminates the table early.
    localparam logic [7:0] END_MARKER = 8'hFF;

    localparam int DEF_IDX_W        = 10;
    localparam int DEF_LUT_LEN      = 64;
    localparam int DEF_PWR_WAIT     = 20_000_000;
    localparam int DEF_XFER_TIMEOUT = 1_000_000;
    localparam int DEF_RETRY_MAX    = 3;
    localparam int DEF_DEBOUNCE     = 1_000_000;

endpackage

// File: rtl/hpd_debounce.sv
// rtl/hpd_debounce.sv - hot-plug detect synchroniser and debouncer
// Ports: clk, rst_n (async active-low), hpd (asynchronous pin),
//        hpd_rise / hpd_fall (1-cycle pulses when the debounced level changes).
module hpd_debounce
    import hdmi_cfg_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hpd,
    output logic hpd_rise,
    output logic hpd_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [1:0]       sync_q, sync_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter runs only while the synchronised pin disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        sync_d = {sync_q[0], hpd};
        db_d   = db_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = sync_q[1];
                rise_d = sync_q[1];
                fall_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hpd_rise = rise_q;
    assign hpd_fall = fall_q;

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// rtl/hdmi_cfg_sequencer.sv - walks the ADV7511 register LUT issuing I2C writes
// Ports: clk, rst_n, start, hpd; lut_index out / lut_* entry in;
//        i2c_req + i2c_* fields out, i2c_ack / i2c_err in;
//        busy, done, error, err_index status out.
module hdmi_cfg_sequencer
    import hdmi_cfg_pkg::*;
#(
    parameter int IDX_W        = DEF_IDX_W,
    parameter int LUT_LEN      = DEF_LUT_LEN,
    parameter int PWR_WAIT     = DEF_PWR_WAIT,
    parameter int XFER_TIMEOUT = DEF_XFER_TIMEOUT,
    parameter int RETRY_MAX    = DEF_RETRY_MAX,
    parameter int DEBOUNCE     = DEF_DEBOUNCE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hpd,
    output logic [IDX_W-1:0] lut_index,
    input  logic [7:0]       lut_dev_addr,
    input  logic [15:0]      lut_reg_addr,
    input  logic [7:0]       lut_reg_data,
    output logic             i2c_req,
    output logic [7:0]       i2c_dev_addr,
    output logic [15:0]      i2c_reg_addr,
    output logic [7:0]       i2c_reg_data,
    input  logic             i2c_ack,
    input  logic             i2c_err,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);

    // One timer serves both the power-up wait and the per-transfer timeout.
    localparam int TMR_W = $clog2((PWR_WAIT > XFER_TIMEOUT ? PWR_WAIT : XFER_TIMEOUT) + 1);
    localparam int RTY_W = $clog2(RETRY_MAX + 1);
    localparam logic [TMR_W-1:0] PWR_LAST = TMR_W'(PWR_WAIT - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(XFER_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(LUT_LEN);

    logic hpd_rise, hpd_fall;

    hpd_debounce #(.DEBOUNCE(DEBOUNCE)) u_hpd_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .hpd     (hpd),
        .hpd_rise(hpd_rise),
        .hpd_fall(hpd_fall)
    );

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic [7:0]       dev_q, dev_d;
    logic [15:0]      reg_q, reg_d;
    logic [7:0]       dat_q, dat_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             abort_q, abort_d;
    logic             abort_now, run_now, idle_now;

    // A hot-unplug seen while busy is remembered until the FSM reaches a
    // point where it can drop out without cutting a handshake short.
    assign abort_now = abort_q | (hpd_fall & busy_q);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        rty_d     = rty_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        dat_d     = dat_q;
        req_d     = req_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        abort_d   = abort_now;
        run_now   = 1'b0;
        idle_now  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                run_now = start | hpd_rise;
            end
            ST_WAIT_PWR: begin
                if (abort_now) begin
                    idle_now = 1'b1;
                end else if (tmr_q == PWR_LAST) begin
                    tmr_d   = '0;
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_FETCH: begin
                if (abort_now) begin
                    idle_now = 1'b1;
                end else begin
                    dev_d = lut_dev_addr;
                    reg_d = lut_reg_addr;
                    dat_d = lut_reg_data;
                    if (lut_dev_addr == END_MARKER) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (abort_now) begin
                    idle_now = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // err has priority so a simultaneous ack+err is retried.
                if (i2c_err || (!i2c_ack && tmr_q == TMO_LAST)) begin
                    req_d   = 1'b0;
                    state_d = ST_RETRY;
                    idle_now = abort_now;
                end else if (i2c_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_NEXT;
                    idle_now = abort_now;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_NEXT: begin
                if (abort_now) begin
                    idle_now = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    rty_d = '0;
                    if (idx_q + IDX_W'(1) == IDX_END) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_RETRY: begin
                if (abort_now) begin
                    idle_now = 1'b1;
                end else if (rty_q < RTY_LIM) begin
                    rty_d   = rty_q + RTY_W'(1);
                    state_d = ST_REQ;
                end else begin
                    err_idx_d = idx_q;
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_FAIL;
                end
            end
            default: begin
                idle_now = 1'b1;
            end
        endcase

        if (idle_now) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b0;
            abort_d = 1'b0;
        end
        if (run_now) begin
            state_d   = ST_WAIT_PWR;
            tmr_d     = '0;
            rty_d     = '0;
            idx_d     = '0;
            err_idx_d = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            error_d   = 1'b0;
            abort_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            rty_q     <= '0;
            idx_q     <= '0;
            err_idx_q <= '0;
            dev_q     <= '0;
            reg_q     <= '0;
            dat_q     <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            rty_q     <= rty_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            dat_q     <= dat_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            abort_q   <= abort_d;
        end
    end

    assign lut_index    = idx_q;
    assign i2c_req      = req_q;
    assign i2c_dev_addr = dev_q;
    assign i2c_reg_addr = reg_q;
    assign i2c_reg_data = dat_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_index    = err_idx_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// tb/tb_hdmi_cfg_sequencer.sv - directed self-checking bench for hdmi_cfg_sequencer
module tb_hdmi_cfg_sequencer;
    import hdmi_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        hpd = 1'b0;
    logic [9:0]  lut_index;
    logic [7:0]  lut_dev_addr;
    logic [15:0] lut_reg_addr;
    logic [7:0]  lut_reg_data;
    logic        i2c_req;
    logic [7:0]  i2c_dev_addr;
    logic [15:0] i2c_reg_addr;
    logic [7:0]  i2c_reg_data;
    logic        i2c_ack = 1'b0;
    logic        i2c_err = 1'b0;
    logic        busy, done, error;
    logic [9:0]  err_index;

    hdmi_cfg_sequencer #(
        .IDX_W(10), .LUT_LEN(4), .PWR_WAIT(10), .XFER_TIMEOUT(50),
        .RETRY_MAX(2), .DEBOUNCE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hpd(hpd),
        .lut_index(lut_index), .lut_dev_addr(lut_dev_addr),
        .lut_reg_addr(lut_reg_addr), .lut_reg_data(lut_reg_data),
        .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr),
        .i2c_reg_addr(i2c_reg_addr), .i2c_reg_data(i2c_reg_data),
        .i2c_ack(i2c_ack), .i2c_err(i2c_err),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    // LUT model: entry i = {dev 0x72, reg 0x0100+i, data 0xA0+i}; end_idx marks the end.
    logic [9:0] end_idx = 10'd99;
    always_comb begin
        lut_dev_addr = (lut_index == end_idx) ? END_MARKER : 8'h72;
        lut_reg_addr = 16'h0100 + {6'd0, lut_index};
        lut_reg_data = 8'hA0 + lut_index[7:0];
    end

    // Master model. mode 0: ack; 1: err on sel; 2: silent on sel; 3: ack+err on first try of sel.
    int         mode = 0;
    int         sel = 0;
    int         n_req = 0;
    int         tries [0:15];
    logic [31:0] log_ent [0:15];
    logic [31:0] cur_ent;
    int         age = 0;
    int         last_width = 0;
    logic       in_req = 1'b0;
    logic       unstable = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) tries[i] = 0;
        forever begin
            @(negedge clk);
            i2c_ack = 1'b0;
            i2c_err = 1'b0;
            if (i2c_req) begin
                if (!in_req) begin
                    in_req  = 1'b1;
                    age     = 0;
                    cur_ent = {i2c_dev_addr, i2c_reg_addr, i2c_reg_data};
                    if (n_req < 16) log_ent[n_req] = cur_ent;
                    n_req++;
                    tries[i2c_reg_addr[3:0]]++;
                end else begin
                    age++;
                    if ({i2c_dev_addr, i2c_reg_addr, i2c_reg_data} != cur_ent) unstable = 1'b1;
                end
                if (age == 4) begin
                    if (mode == 1 && int'(cur_ent[11:8]) == sel) begin
                        i2c_err = 1'b1;
                    end else if (mode == 2 && int'(cur_ent[11:8]) == sel) begin
                        i2c_ack = 1'b0;
                    end else if (mode == 3 && int'(cur_ent[11:8]) == sel && tries[sel] == 1) begin
                        i2c_ack = 1'b1;
                        i2c_err = 1'b1;
                    end else begin
                        i2c_ack = 1'b1;
                    end
                end
            end else if (in_req) begin
                in_req     = 1'b0;
                last_width = age + 1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic clear_log();
        n_req = 0;
        unstable = 1'b0;
        for (int i = 0; i < 16; i++) tries[i] = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] ent(input int i);
        return {8'h72, 16'h0100 + 16'(i), 8'hA0 + 8'(i)};
    endfunction

    int lat;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, i2c_req}, 32'd0);
        chk("rst_status", {28'd0, busy, done, error, 1'b0}, 32'd0);
        chk("rst_idx", {22'd0, lut_index}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: full table, first req on the 12th edge after the accepting edge
        clear_log();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 1;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        while (!i2c_req && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", lat, 13);
        wait_idle("t1_end");
        chk("t1_nreq", n_req, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_ent%0d", i), log_ent[i], ent(i));
        chk("t1_done_err", {30'd0, done, error}, 32'd2);
        chk("t1_stable", {31'd0, unstable}, 32'd0);

        // 2: end marker at entry 2
        clear_log();
        end_idx = 10'd2;
        pulse_start();
        chk("t2_done_cleared", {31'd0, done}, 32'd0);
        wait_idle("t2_end");
        chk("t2_nreq", n_req, 2);
        chk("t2_ent1", log_ent[1], ent(1));
        chk("t2_done", {31'd0, done}, 32'd1);

        // 5: glitch while DONE, then a clean replug
        clear_log();
        end_idx = 10'd99;
        @(negedge clk) hpd = 1'b1;
        repeat (2) @(negedge clk);
        hpd = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_glitch_busy", {31'd0, busy}, 32'd0);
        chk("t5_glitch_done", {31'd0, done}, 32'd1);
        hpd = 1'b1;
        for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
        chk("t5_replug_busy", {31'd0, busy}, 32'd1);
        chk("t5_replug_done_clr", {31'd0, done}, 32'd0);
        wait_idle("t5_end");
        chk("t5_nreq", n_req, 4);
        chk("t5_done", {31'd0, done}, 32'd1);
        hpd = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_unplug_idle", {30'd0, busy, done}, 32'd1);

        // 3: idx 1 always errors
        clear_log();
        mode = 1;
        sel = 1;
        pulse_start();
        wait_idle("t3_end");
        chk("t3_nreq", n_req, 4);
        chk("t3_tries1", tries[1], 3);
        chk("t3_flags", {30'd0, done, error}, 32'd1);
        chk("t3_err_index", {22'd0, err_index}, 32'd1);

        // 4: master silent on idx 0
        clear_log();
        mode = 2;
        sel = 0;
        pulse_start();
        chk("t4_err_clr", {31'd0, error}, 32'd0);
        wait_idle("t4_end");
        chk("t4_tries0", tries[0], 3);
        chk("t4_nreq", n_req, 3);
        chk("t4_width", last_width, 50);
        chk("t4_flags", {30'd0, done, error}, 32'd1);
        chk("t4_err_index", {22'd0, err_index}, 32'd0);

        // 6a: ack+err together on first try of idx 0 -> retried
        clear_log();
        mode = 3;
        sel = 0;
        pulse_start();
        wait_idle("t6a_end");
        chk("t6a_nreq", n_req, 5);
        chk("t6a_ent0", log_ent[0], ent(0));
        chk("t6a_ent1", log_ent[1], ent(0));
        chk("t6a_done", {30'd0, done, error}, 32'd2);

        // 6b: reset while waiting for ack
        clear_log();
        mode = 2;
        sel = 0;
        pulse_start();
        for (int i = 0; i < 40 && !i2c_req; i++) @(negedge clk);
        chk("t6b_req_up", {31'd0, i2c_req}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6b_req_async", {31'd0, i2c_req}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("t6b_status", {28'd0, i2c_req, busy, done, error}, 32'd0);
        chk("t6b_idx", {12'd0, lut_index, err_index}, 32'd0);
        chk("t6b_fields", {i2c_dev_addr, i2c_reg_addr, i2c_reg_data}, 32'd0);
        chk("t6b_state", {28'd0, dut.state_q}, {28'd0, ST_IDLE});
        repeat (20) @(negedge clk);
        chk("t6b_stays_idle", {30'd0, busy, i2c_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
